// File: rtl/path_move_encoder_if.sv
// path_move_encoder_if
//   Bundles the path-cell input stream and the move output stream of
//   path_move_encoder.
//   master : the side that drives cells and consumes moves (solver/host side)
//   slave  : the encoder itself
//   Signals: start_path, load, cell_row, cell_col, path_done, move_ready (to encoder)
//            move_valid, move_dir, move_last, finished, busy, error, move_count (from encoder)
interface path_move_encoder_if #(
  parameter int COORD_W = 4
);
  logic               start_path;
  logic               load;
  logic [COORD_W-1:0] cell_row;
  logic [COORD_W-1:0] cell_col;
  logic               path_done;
  logic               move_ready;
  logic               move_valid;
  logic [1:0]         move_dir;
  logic               move_last;
  logic               finished;
  logic               busy;
  logic               error;
  logic [7:0]         move_count;

  modport master (
    output start_path, load, cell_row, cell_col, path_done, move_ready,
    input  move_valid, move_dir, move_last, finished, busy, error, move_count
  );

  modport slave (
    input  start_path, load, cell_row, cell_col, path_done, move_ready,
    output move_valid, move_dir, move_last, finished, busy, error, move_count
  );
endinterface

// File: rtl/path_move_encoder.sv
// path_move_encoder
//   Turns a replayed solved path (one cell per load pulse) into 2-bit moves,
//   buffers them in a small FIFO and streams them out over valid/ready.
//   Move codes: 00 up (row-1), 01 right (col+1), 10 down (row+1), 11 left (col-1).
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
//   bus  path_move_encoder_if.slave (cell input stream, move output stream, status)
// Build option:
//   MOVE_COUNT_EN  when defined, move_count counts accepted moves (saturating at 255);
//                  otherwise move_count is tied to zero and no counter exists.
module path_move_encoder #(
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  path_move_encoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [COORD_W-1:0] STEP_P = COORD_W'(1);
  localparam logic [COORD_W-1:0] STEP_M = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] STEP_0 = {COORD_W{1'b0}};

  state_t             state_q, state_d;
  logic [COORD_W-1:0] prev_row_q, prev_row_d;
  logic [COORD_W-1:0] prev_col_q, prev_col_d;
  logic               push_q, push_d;
  logic [1:0]         push_dir_q, push_dir_d;
  logic [1:0]         mem_q [FIFO_DEPTH];
  logic [1:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               error_q, error_d;
  logic [7:0]         count_q, count_d;

  logic               empty_s, full_s, pop_s, do_push_s, overflow_s;
  logic [PTR_W:0]     occupancy_s;
  logic [COORD_W-1:0] d_row_s, d_col_s;
  logic               step_ok_s;
  logic [1:0]         step_dir_s;

  assign empty_s     = (wr_ptr_q == rd_ptr_q);
  assign full_s      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign occupancy_s = wr_ptr_q - rd_ptr_q;
  assign pop_s       = !empty_s && bus.move_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_push_s   = push_q && (!full_s || pop_s);
  assign overflow_s  = push_q && full_s && !pop_s;

  // Modular per-axis difference, so 15 -> 0 is a +1 step.
  assign d_row_s = bus.cell_row - prev_row_q;
  assign d_col_s = bus.cell_col - prev_col_q;

  // Classify the step from the previous cell: exactly one axis moving by one.
  always_comb begin
    step_ok_s  = 1'b0;
    step_dir_s = 2'b00;
    if (d_row_s == STEP_0 && d_col_s == STEP_P) begin
      step_ok_s  = 1'b1;
      step_dir_s = 2'b01;
    end else if (d_row_s == STEP_0 && d_col_s == STEP_M) begin
      step_ok_s  = 1'b1;
      step_dir_s = 2'b11;
    end else if (d_col_s == STEP_0 && d_row_s == STEP_P) begin
      step_ok_s  = 1'b1;
      step_dir_s = 2'b10;
    end else if (d_col_s == STEP_0 && d_row_s == STEP_M) begin
      step_ok_s  = 1'b1;
      step_dir_s = 2'b00;
    end else begin
      step_ok_s  = 1'b0;
      step_dir_s = 2'b00;
    end
  end

  // Next-state logic: FSM, cell encoding, FIFO pointers, error and counter.
  always_comb begin
    state_d    = state_q;
    prev_row_d = prev_row_q;
    prev_col_d = prev_col_q;
    push_d     = 1'b0;
    push_dir_d = push_dir_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    error_d    = error_q;
    count_d    = count_q;

    if (do_push_s) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_dir_q;
      wr_ptr_d                   = wr_ptr_q + (PTR_W+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (overflow_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end

`ifdef MOVE_COUNT_EN
    if (pop_s && count_q != 8'd255) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FIRST: begin
        // The first cell only seeds the previous-cell registers.
        if (bus.load) begin
          prev_row_d = bus.cell_row;
          prev_col_d = bus.cell_col;
          state_d    = STREAM;
        end else if (bus.path_done) begin
          state_d = FINISH;
        end else begin
          state_d = FIRST;
        end
      end
      STREAM: begin
        if (bus.load) begin
          prev_row_d = bus.cell_row;
          prev_col_d = bus.cell_col;
          if (step_ok_s) begin
            push_d     = 1'b1;
            push_dir_d = step_dir_s;
          end else begin
            error_d = 1'b1;
          end
        end else begin
          push_d = 1'b0;
        end
        if (bus.path_done) begin
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        // Wait for any in-flight push as well as an empty FIFO.
        if (empty_s && !push_q) begin
          state_d = FINISH;
        end else begin
          state_d = DRAIN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart overrides everything else, including a simultaneous load.
    if (bus.start_path) begin
      state_d  = FIRST;
      push_d   = 1'b0;
      wr_ptr_d = {(PTR_W+1){1'b0}};
      rd_ptr_d = {(PTR_W+1){1'b0}};
      error_d  = 1'b0;
      count_d  = 8'd0;
    end else begin
      state_d = state_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_row_q <= {COORD_W{1'b0}};
      prev_col_q <= {COORD_W{1'b0}};
      push_q     <= 1'b0;
      push_dir_q <= 2'b00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 2'b00;
      end
      wr_ptr_q   <= {(PTR_W+1){1'b0}};
      rd_ptr_q   <= {(PTR_W+1){1'b0}};
      error_q    <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_row_q <= prev_row_d;
      prev_col_q <= prev_col_d;
      push_q     <= push_d;
      push_dir_q <= push_dir_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign bus.move_valid = !empty_s;
  assign bus.move_dir   = mem_q[rd_ptr_q[PTR_W-1:0]];
  // Last only when the single remaining entry has nothing queued behind it.
  assign bus.move_last  = !empty_s && (state_q == DRAIN) &&
                          (occupancy_s == (PTR_W+1)'(1)) && !push_q;
  assign bus.finished   = (state_q == FINISH);
  assign bus.busy       = (state_q != IDLE);
  assign bus.error      = error_q;
  assign bus.move_count = count_q;

endmodule
